// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction memory port, decode handshake,
// redirect inputs from execute and the status flags.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] ex_pc;
  logic [31:0] immout;
  logic [31:0] rs1_val;
  logic        br_taken;
  logic        jal;
  logic        jalr;
  logic        misalign;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc, misalign, fetch_err,
    input  imem_ack, imem_rdata, inst_ready, ex_pc, immout, rs1_val, br_taken, jal, jalr
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, misalign, fetch_err,
    output imem_ack, imem_rdata, inst_ready, ex_pc, immout, rs1_val, br_taken, jal, jalr
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC holder and single-outstanding instruction fetcher with branch/jal/jalr
// redirect, stale-response kill and an ack-timeout flag.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input logic             Clk_CPU,
  input logic             rst,
  pc_fetch_ctrl_if.master bus
);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q, addr_q, inst_q, ipc_q;
  logic [7:0]  wait_q;
  logic        req_q, kill_q, valid_q, mis_q, err_q;
  logic        redir, ack;
  logic [31:0] tgt_raw, tgt, pc_d;

  always_comb begin
    redir   = bus.br_taken | bus.jal | bus.jalr;
    tgt_raw = bus.jalr ? ((bus.rs1_val + bus.immout) & ~32'd1) : (bus.ex_pc + bus.immout);
    tgt     = {tgt_raw[31:2], 2'b00};
    ack     = req_q & bus.imem_ack;
    // A redirect takes the PC in every state and beats a same-cycle accept.
    if (redir)                                  pc_d = tgt;
    else if (state_q == HOLD && bus.inst_ready) pc_d = pc_q + 32'd4;
    else                                        pc_d = pc_q;
  end

  always_ff @(posedge Clk_CPU) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= redir && (tgt_raw[1:0] != 2'b00);
      if (ack) wait_q <= '0;
      else if (req_q) begin
        if (wait_q == WAIT_LAST) err_q <= 1'b1;
        else                     wait_q <= wait_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_d;
        end
        FETCH: begin
          if (!req_q) begin
            // one-cycle gap after a discarded response; reissue at current pc
            req_q  <= 1'b1;
            addr_q <= pc_d;
          end else if (ack) begin
            req_q  <= 1'b0;
            kill_q <= 1'b0;
            if (!kill_q && !redir) begin
              inst_q  <= bus.imem_rdata;
              ipc_q   <= pc_q;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (redir) begin
            // request in flight keeps its address; its response gets dropped
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redir || bus.inst_ready) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_out   = inst_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.misalign   = mis_q;
  assign bus.fetch_err  = err_q;
endmodule
